// File: rtl/chess_pkg.sv
// Shared constants for the move-generation slice: piece/colour codes,
// move-word layout and the sequencer state encoding.
package chess_pkg;

    // Square code is {colour, piece[2:0]}
    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] PAWN    = 3'd1;
    localparam logic [2:0] KNIGHT  = 3'd2;
    localparam logic [2:0] BISHOP  = 3'd3;
    localparam logic [2:0] ROOK    = 3'd4;
    localparam logic [2:0] QUEEN   = 3'd5;
    localparam logic [2:0] KING    = 3'd6;
    localparam logic [2:0] NOTUSED = 3'd7;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    // Move word {from_x, from_y, to_x, to_y, piece}
    localparam int MOVE_W        = 15;
    localparam int MV_PIECE_LSB  = 0;
    localparam int MV_TO_Y_LSB   = 3;
    localparam int MV_TO_X_LSB   = 6;
    localparam int MV_FROM_Y_LSB = 9;
    localparam int MV_FROM_X_LSB = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEED,
        S_PROP,
        S_DRAIN,
        S_DONE
    } mg_state_e;

endpackage

// File: rtl/movegen_ctrl_if.sv
// Valid/ready move stream out of the sequencer.
// master: drives mv_valid/mv_data, samples mv_ready; slave: the reverse.
interface movegen_ctrl_if
    import chess_pkg::*;
#(
    parameter int MOVE_W = chess_pkg::MOVE_W
);
    logic              mv_valid;
    logic [MOVE_W-1:0] mv_data;
    logic              mv_ready;

    modport master (
        output mv_valid,
        output mv_data,
        input  mv_ready
    );

    modport slave (
        input  mv_valid,
        input  mv_data,
        output mv_ready
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin pick starting at ptr, wrapping 7->0.
// In: req[7:0], ptr[2:0]. Out: gnt (one-hot), gnt_idx, any.
module rr_arbiter8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       any
);
    logic [2:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt[gnt_idx] = any;
    end
endmodule

// File: rtl/movegen_ctrl.sv
// Sequencer for the 8x8 cell array: load board, seed, propagate, drain moves.
// Ports: clk/reset/start, busy/done/move_count, board RAM read, cell writes,
// newboard seed, per-column FIFO pops, and the mv stream interface (master).
module movegen_ctrl
    import chess_pkg::*;
#(
    parameter int PROP_CYCLES = 7,
    parameter int MOVE_W      = chess_pkg::MOVE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            move_count,
    output logic [5:0]            brd_rd_addr,
    input  logic [3:0]            brd_rd_data,
    output logic                  cell_we,
    output logic [5:0]            cell_addr,
    output logic [3:0]            cell_piece,
    output logic                  newboard,
    input  logic [7:0]            col_empty,
    output logic [7:0]            col_rd,
    input  logic [8*MOVE_W-1:0]   col_data,
    movegen_ctrl_if.master        mv
);
    mg_state_e         state;
    logic [6:0]        cnt;
    logic [2:0]        rr_ptr;

    logic [7:0]        gnt;
    logic [2:0]        gnt_idx;
    logic              any;
    logic              out_free;
    logic              pop;
    logic [MOVE_W-1:0] col_word;

    rr_arbiter8 u_arb (
        .req     (~col_empty),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign out_free = !mv.mv_valid || mv.mv_ready;

    // Pop in the same cycle the output register loads (FWFT FIFOs)
    assign pop      = (state == S_DRAIN) && out_free && any && !reset;
    assign col_rd   = pop ? gnt : 8'h00;
    assign col_word = col_data[32'(gnt_idx)*MOVE_W +: MOVE_W];

    // RAM data arrives in the cycle the write strobe is up
    assign cell_piece = cell_we ? brd_rd_data : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            move_count  <= '0;
            brd_rd_addr <= '0;
            cell_we     <= 1'b0;
            cell_addr   <= '0;
            newboard    <= 1'b0;
            mv.mv_valid <= 1'b0;
            mv.mv_data  <= '0;
        end else begin
            done     <= 1'b0;
            cell_we  <= 1'b0;
            newboard <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        cnt         <= '0;
                        brd_rd_addr <= '0;
                        move_count  <= '0;
                        rr_ptr      <= '0;
                        busy        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // cnt 0..63 issues reads; cnt 64 is the trailing write
                    if (cnt == 7'd64) begin
                        state    <= S_SEED;
                        newboard <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cell_we     <= 1'b1;
                        cell_addr   <= brd_rd_addr;
                        brd_rd_addr <= brd_rd_addr + 6'd1;
                        cnt         <= cnt + 7'd1;
                    end
                end
                S_SEED: begin
                    state <= S_PROP;
                    cnt   <= '0;
                end
                S_PROP: begin
                    if (cnt == 7'(PROP_CYCLES - 1)) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (out_free) begin
                        if (any) begin
                            mv.mv_valid <= 1'b1;
                            mv.mv_data  <= col_word;
                            rr_ptr      <= gnt_idx + 3'd1;
                            if (move_count != 8'hFF)
                                move_count <= move_count + 8'd1;
                        end else begin
                            mv.mv_valid <= 1'b0;
                            state       <= S_DONE;
                            done        <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_movegen_ctrl.sv
// Directed bench for movegen_ctrl: load path, empty drain, round-robin,
// backpressure, saturation, reset mid-drain and start while busy.
module tb_movegen_ctrl;
    import chess_pkg::*;

    localparam int P = 7;
    localparam int W = MOVE_W;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           busy;
    logic           done;
    logic [7:0]     move_count;
    logic [5:0]     brd_rd_addr;
    logic [3:0]     brd_rd_data;
    logic           cell_we;
    logic [5:0]     cell_addr;
    logic [3:0]     cell_piece;
    logic           newboard;
    logic [7:0]     col_empty;
    logic [7:0]     col_rd;
    logic [8*W-1:0] col_data;

    movegen_ctrl_if #(.MOVE_W(W)) mv ();

    movegen_ctrl #(.PROP_CYCLES(P), .MOVE_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .move_count  (move_count),
        .brd_rd_addr (brd_rd_addr),
        .brd_rd_data (brd_rd_data),
        .cell_we     (cell_we),
        .cell_addr   (cell_addr),
        .cell_piece  (cell_piece),
        .newboard    (newboard),
        .col_empty   (col_empty),
        .col_rd      (col_rd),
        .col_data    (col_data),
        .mv          (mv.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM, 1-cycle read latency
    logic [3:0] ram [64];
    always @(posedge clk) brd_rd_data <= ram[brd_rd_addr];

    // Per-column FWFT FIFOs
    logic [W-1:0] fmem [8][512];
    int head [8];
    int tail [8];

    always @(posedge clk)
        for (int c = 0; c < 8; c++)
            if (col_rd[c] && head[c] != tail[c])
                head[c] <= head[c] + 1;

    for (genvar g = 0; g < 8; g++) begin : g_fifo
        assign col_empty[g]         = (head[g] == tail[g]);
        assign col_data[g*W +: W]   = fmem[g][head[g][8:0]];
    end

    // Monitor
    int wr_cnt = 0, wr_bad = 0, we_first = 0, we_last = 0;
    int nb_cnt = 0, nb_cyc = 0, done_cnt = 0, done_cyc = 0;
    int mv_seen = 0, rd_bad = 0, stab_bad = 0, stall_rd_bad = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [W-1:0] outq [$];

    always @(negedge clk) begin
        if (cell_we) begin
            if (cell_addr != 6'(wr_cnt % 64) || cell_piece != cell_addr[3:0])
                wr_bad <= wr_bad + 1;
            if (wr_cnt % 64 == 0) we_first <= cyc;
            if (wr_cnt % 64 == 63) we_last <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if (newboard) begin
            nb_cnt <= nb_cnt + 1;
            nb_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (mv.mv_valid) mv_seen <= mv_seen + 1;
        if (col_rd != 0 && ($countones(col_rd) != 1 || (col_rd & col_empty) != 0))
            rd_bad <= rd_bad + 1;
        if (stall_prev && (!mv.mv_valid || mv.mv_data != prev_data))
            stab_bad <= stab_bad + 1;
        if (mv.mv_valid && !mv.mv_ready && col_rd != 0)
            stall_rd_bad <= stall_rd_bad + 1;
        stall_prev <= mv.mv_valid && !mv.mv_ready && !reset;
        prev_data  <= mv.mv_data;
        if (mv.mv_valid && mv.mv_ready && !reset)
            outq.push_back(mv.mv_data);
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] wd(input int c, input int k);
        logic [W-1:0] r;
        r = {3'(c), 12'(k)};
        return r;
    endfunction

    task automatic push(input int c, input logic [W-1:0] w);
        fmem[c][tail[c]] = w;
        tail[c]++;
    endtask

    // Called at posedge+1; returns the start cycle T
    task automatic run_start(output int t);
        start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [W-1:0] expq [$];
    int t, d0, o0, wr0, nb0, mv0, sr0, nmis;
    bit ok;

    initial begin
        for (int a = 0; a < 64; a++) ram[a] = 4'(a % 16);
        reset = 1'b1;
        start = 1'b0;
        mv.mv_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mcnt", move_count, 0);
        chk("rst_nb", newboard, 0);
        chk("rst_we", {cell_we, cell_addr, cell_piece}, 0);
        chk("rst_addr", brd_rd_addr, 0);
        chk("rst_colrd", col_rd, 0);
        chk("rst_mv", {mv.mv_valid, mv.mv_data}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load path + empty drain
        wr0 = wr_cnt; nb0 = nb_cnt; mv0 = mv_seen; d0 = done_cnt;
        run_start(t);
        chk("busy_rise", busy, 1);
        wait_done(d0, ok);
        chk("empty_done_seen", ok, 1);
        chk("empty_done_cyc", done_cyc, t + 75);
        chk("empty_busy_fall", busy, 0);
        chk("load_wr_cnt", wr_cnt - wr0, 64);
        chk("load_wr_bad", wr_bad, 0);
        chk("load_first_we", we_first, t + 2);
        chk("load_last_we", we_last, t + 65);
        chk("nb_cnt", nb_cnt - nb0, 1);
        chk("nb_cyc", nb_cyc, t + 66);
        chk("empty_mcnt", move_count, 0);
        chk("empty_mv_seen", mv_seen - mv0, 0);

        // Round-robin
        expq.delete();
        for (int k = 0; k < 2; k++) begin
            push(0, wd(0, k)); push(3, wd(3, k)); push(7, wd(7, k));
            expq.push_back(wd(0, k));
            expq.push_back(wd(3, k));
            expq.push_back(wd(7, k));
        end
        o0 = outq.size(); d0 = done_cnt;
        run_start(t);
        wait_done(d0, ok);
        chk("rr_done", ok, 1);
        chk("rr_count", outq.size() - o0, 6);
        for (int i = 0; i < 6; i++)
            if (o0 + i < outq.size())
                chk($sformatf("rr_word%0d", i), outq[o0 + i], expq[i]);
        chk("rr_mcnt", move_count, 6);

        // Backpressure
        expq.delete();
        for (int k = 0; k < 3; k++) begin
            push(1, wd(1, k)); push(2, wd(2, k));
            expq.push_back(wd(1, k));
            expq.push_back(wd(2, k));
        end
        o0 = outq.size(); d0 = done_cnt; sr0 = stall_rd_bad;
        run_start(t);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (outq.size() - o0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_reach_mid", ok, 1);
        chk("bp_valid_at_stall", mv.mv_valid, 1);
        mv.mv_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 mv.mv_ready = 1'b1;
        wait_done(d0, ok);
        chk("bp_done", ok, 1);
        chk("bp_count", outq.size() - o0, 6);
        nmis = 0;
        for (int i = 0; i < 6; i++)
            if (o0 + i >= outq.size() || outq[o0 + i] != expq[i]) nmis++;
        chk("bp_order", nmis, 0);
        chk("bp_stall_rd", stall_rd_bad - sr0, 0);
        chk("bp_stable", stab_bad, 0);
        chk("bp_mcnt", move_count, 6);

        // Saturation: 300 words, cols 0..3 hold 38, cols 4..7 hold 37
        expq.delete();
        for (int k = 0; k < 38; k++)
            for (int c = 0; c < 8; c++)
                if (c < 4 || k < 37) begin
                    push(c, wd(c, k));
                    expq.push_back(wd(c, k));
                end
        o0 = outq.size(); d0 = done_cnt;
        run_start(t);
        wait_done(d0, ok);
        chk("sat_done", ok, 1);
        chk("sat_count", outq.size() - o0, 300);
        nmis = 0;
        for (int i = 0; i < 300; i++)
            if (o0 + i >= outq.size() || outq[o0 + i] != expq[i]) nmis++;
        chk("sat_order", nmis, 0);
        chk("sat_mcnt", move_count, 255);

        // Reset mid-drain with mv_valid high
        for (int k = 0; k < 4; k++) begin
            push(4, wd(4, k)); push(5, wd(5, k));
        end
        d0 = done_cnt;
        run_start(t);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (mv.mv_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_valid", ok, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mv", mv.mv_valid, 0);
        chk("rst_mid_colrd", col_rd, 0);
        chk("rst_mid_nodone", done_cnt - d0, 0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) tail[c] = head[c];
        @(posedge clk);
        #1;

        // Start while busy is ignored
        d0 = done_cnt;
        run_start(t);
        repeat (68) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(d0, ok);
        chk("sb_done", ok, 1);
        chk("sb_done_cyc", done_cyc, t + 75);
        repeat (20) @(posedge clk);
        #1;
        chk("sb_one_done", done_cnt - d0, 1);
        chk("sb_idle", busy, 0);

        chk("colrd_onehot", rd_bad, 0);
        chk("stall_no_pop", stall_rd_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/movegen_ctrl.md
# movegen_ctrl

Sequencer for the 8x8 `cellUnit` move-generation array. On `start` it:
- copies the 64-square board from board RAM into the array's piece registers;
- seeds the array with one `newboard` cycle;
- lets sliding pieces propagate for a fixed number of cycles;
- drains the eight per-column move FIFOs through a round-robin arbiter into one valid/ready move stream, then reports completion and the move count.

It sits between the board store / search controller and the cell array.

## Interface
Parameters:
- PROP_CYCLES, 7: propagation cycles after the seed; 7 covers a full-board slide.
- MOVE_W, 15: move word {from_x[2:0], from_y[2:0], to_x[2:0], to_y[2:0], piece[2:0]}.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- move_count  out  8  moves emitted by the last run, saturating at 255; held until the next start.
- brd_rd_addr  out  6  board RAM read address {y,x}; RAM read latency is 1 cycle.
- brd_rd_data  in  4  square code {colour, piece[2:0]}.
- cell_we  out  1  write strobe to the array piece register.
- cell_addr  out  6  target square for cell_we.
- cell_piece  out  4  piece value written.
- newboard  out  1  seed strobe to all cells.
- col_empty  in  8  per-column FIFO empty flags.
- col_rd  out  8  one-hot pop; FIFOs are first-word-fall-through.
- col_data  in  8*MOVE_W  head word of each FIFO; column c occupies [c*MOVE_W +: MOVE_W].
- mv_valid  out  1  output move valid.
- mv_data  out  MOVE_W  output move.
- mv_ready  in  1  consumer accept.

## Operation
FSM states: IDLE, LOAD, SEED, PROP, DRAIN, DONE.
- **IDLE**
  - start moves to LOAD.
  - On that transition: address counter := 0, move counter := 0, RR pointer := 0.
- **LOAD**
  - Issue brd_rd_addr = 0..63, one per cycle.
  - One cycle after issuing address a: cell_we=1, cell_addr=a, cell_piece=brd_rd_data.
  - Lasts 65 cycles: 64 issues plus 1 trailing write. Then go to SEED.
- **SEED**
  - newboard=1 for exactly one cycle, then PROP.
- **PROP**
  - newboard=0. Count PROP_CYCLES cycles, then DRAIN.
  - FIFOs fill during PROP and are not popped.
- **DRAIN**: single output register. Each cycle where (!mv_valid || mv_ready):
  - Search columns starting at the RR pointer, wrapping 7→0, for the first with !col_empty.
  - If column g is found: col_rd[g]=1, mv_data := col_data[g], mv_valid := 1, pointer := g+1 mod 8, move_count += 1 (sticks at 255).
  - If none is found: mv_valid := 0.
  - Exit to DONE when all col_empty and (!mv_valid || mv_ready) in the same cycle, i.e. the last word has been accepted and nothing remains.
- **DONE**
  - done=1 for one cycle, then IDLE.
- mv_data is held stable while mv_valid && !mv_ready.
- At most one col_rd bit is high per cycle, and col_rd is never asserted for an empty column.
- start outside IDLE is ignored.
- reset in any state forces IDLE next cycle and drops all strobes. An in-flight mv_valid is dropped and the partial run is discarded.

## Timing
- Reset values:
  - busy=0, done=0, move_count=0, newboard=0.
  - cell_we=0, cell_addr=0, cell_piece=0, brd_rd_addr=0.
  - col_rd=0, mv_valid=0, mv_data=0.
- start at cycle T:
  - busy=1 from T+1.
  - First cell_we at T+2, last cell_we at T+65.
  - newboard at T+66.
  - PROP over T+67..T+66+PROP_CYCLES.
  - DRAIN starts at T+67+PROP_CYCLES.
- With all FIFOs empty, DRAIN lasts 1 cycle and done is asserted on the following cycle. Default total is T+75 for done, with busy falling at T+76.
- Drain throughput is one move per cycle while mv_ready=1.
- col_rd coincides with the cycle in which mv_data is loaded.

## Structure
- Shared package `chess_pkg` holds:
  - piece and colour constants: EMPTY..NOTUSED, WHITE, BLACK;
  - MOVE_W and the move-word field offsets;
  - the FSM state enum.
- One sub-module: `rr_arbiter8`. Combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: gnt one-hot, gnt_idx, any.
  - The pointer register lives in movegen_ctrl.

## Test plan
- **Load path:** RAM holds value (addr mod 16). Pulse start → 64 cell_we writes in order 0..63 with matching cell_piece, newboard high exactly once at T+66.
- **Empty drain:** all col_empty=1. Start → done at T+75, move_count=0, mv_valid never high.
- **Round-robin:** columns 0, 3 and 7 each hold 2 words, mv_ready=1 → output order c0, c3, c7, c0, c3, c7; move_count=6; one-hot col_rd each pop.
- **Backpressure:** mv_ready low for 5 cycles mid-drain → mv_data stable, no col_rd during the stall, no word lost or duplicated.
- **Saturation:** 300 words across FIFOs → move_count=255, all 300 words emitted.
- **Reset mid-DRAIN and start while busy:** reset with mv_valid=1 → next cycle busy=0, mv_valid=0, col_rd=0. start during PROP → ignored, and exactly one done is produced for the run.
